// File: rtl/axis_bist_pkg.sv
// Shared types and helpers for the AXI-Stream loopback BIST endpoint.
package axis_bist_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } bist_state_t;

    // Fibonacci taps 16/14/13/11 expressed as bit positions 15/13/12/10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] next_lfsr(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/axis_bist_lfsr.sv
// 16-bit Fibonacci LFSR with seed and advance enable; exposes the two low
// bits used as independent gap and backpressure decisions.
module axis_bist_lfsr
    import axis_bist_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clk_i,
    input  logic       arstn_i,
    input  logic       en_i,
    output logic [1:0] lfsr_o
);

    logic [15:0] lfsr_q;

    // Shift register loads the seed at reset and steps while enabled
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            lfsr_q <= SEED;
        end else if (en_i) begin
            lfsr_q <= next_lfsr(lfsr_q);
        end
    end

    assign lfsr_o = lfsr_q[1:0];

endmodule

// File: rtl/axis_loopback_bist.sv
// AXI-Stream loopback BIST: sources an incrementing word sequence on the
// master port, checks the returned sequence on the slave port, and guards
// the run with a watchdog.
module axis_loopback_bist
    import axis_bist_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned TO_W   = 10,
    parameter logic [15:0] SEED   = LFSR_SEED_DEFAULT
) (
    input  logic              clk_i,
    input  logic              arstn_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              throttle_en_i,
    input  logic              bp_en_i,
    output logic [DATA_W-1:0] m_axis_tdata_o,
    output logic              m_axis_tvalid_o,
    input  logic              m_axis_tready_i,
    input  logic [DATA_W-1:0] s_axis_tdata_i,
    input  logic              s_axis_tvalid_i,
    output logic              s_axis_tready_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic              timeout_o,
    output logic [LEN_W-1:0]  err_cnt_o,
    output logic [LEN_W-1:0]  first_err_idx_o
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [TO_W-1:0]  WD_ONE  = TO_W'(1);
    // Value one below all-ones: the increment on this edge reaches the limit
    localparam logic [TO_W-1:0]  WD_PRE  = ~WD_ONE;

    bist_state_t      state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] tx_cnt;
    logic [LEN_W-1:0] rx_cnt;
    logic [LEN_W-1:0] err_cnt;
    logic [LEN_W-1:0] first_err_idx;
    logic [TO_W-1:0]  wd_cnt;
    logic             m_hold;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             timeout_q;
    logic [1:0]       lfsr_bits;

    logic              in_run;
    logic              m_valid;
    logic              m_hs;
    logic              s_ready;
    logic              s_hs;
    logic              mismatch;
    logic              rx_last;
    logic              wd_expire;
    logic [DATA_W-1:0] rx_expect;
    logic [LEN_W-1:0]  err_next;

    axis_bist_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .en_i    (state == S_RUN),
        .lfsr_o  (lfsr_bits)
    );

    // Handshake decode, compare and watchdog-expiry terms for this cycle
    always_comb begin
        in_run    = (state == S_RUN);
        // A pending word stays valid regardless of the gap bit
        m_valid   = in_run && (m_hold ||
                    ((tx_cnt < len_q) && !(throttle_en_i && lfsr_bits[0])));
        m_hs      = m_valid && m_axis_tready_i;
        s_ready   = in_run && !(bp_en_i && lfsr_bits[1]);
        s_hs      = s_ready && s_axis_tvalid_i;
        rx_expect = DATA_W'(rx_cnt);
        mismatch  = s_hs && (s_axis_tdata_i != rx_expect);
        err_next  = err_cnt;
        if (mismatch && (err_cnt != '1)) begin
            err_next = err_cnt + LEN_ONE;
        end
        rx_last   = s_hs && ((rx_cnt + LEN_ONE) == len_q);
        wd_expire = in_run && !s_hs && (wd_cnt == WD_PRE);
    end

    // Run control FSM with counters and registered status outputs
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state         <= S_IDLE;
            len_q         <= '0;
            tx_cnt        <= '0;
            rx_cnt        <= '0;
            err_cnt       <= '0;
            first_err_idx <= '1;
            wd_cnt        <= '0;
            m_hold        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        len_q         <= len_i;
                        tx_cnt        <= '0;
                        rx_cnt        <= '0;
                        err_cnt       <= '0;
                        first_err_idx <= '1;
                        wd_cnt        <= '0;
                        m_hold        <= 1'b0;
                        timeout_q     <= 1'b0;
                        if (len_i == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            pass_q <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            busy_q <= 1'b1;
                            pass_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (m_hs) begin
                        tx_cnt <= tx_cnt + LEN_ONE;
                    end
                    m_hold <= m_valid && !m_axis_tready_i;
                    if (s_hs) begin
                        rx_cnt <= rx_cnt + LEN_ONE;
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + WD_ONE;
                    end
                    err_cnt <= err_next;
                    if (mismatch && (first_err_idx == '1)) begin
                        first_err_idx <= rx_cnt;
                    end
                    if (rx_last) begin
                        state  <= S_DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        m_hold <= 1'b0;
                        pass_q <= (err_next == '0);
                    end else if (wd_expire) begin
                        state     <= S_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        m_hold    <= 1'b0;
                        timeout_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign m_axis_tdata_o  = DATA_W'(tx_cnt);
    assign m_axis_tvalid_o = m_valid;
    assign s_axis_tready_o = s_ready;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign timeout_o       = timeout_q;
    assign err_cnt_o       = err_cnt;
    assign first_err_idx_o = first_err_idx;

endmodule

// File: tb/tb_axis_loopback_bist.sv
// Directed bench for axis_loopback_bist: main instance looped through a
// one-stage register slice, second instance (TO_W=4) for the stall case.
module tb_axis_loopback_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance
    logic        start, throttle, bp;
    logic [15:0] len;
    logic [31:0] m_data, s_data;
    logic        m_valid, m_ready, s_valid, s_ready;
    logic        busy, done, pass, tmo;
    logic [15:0] err_cnt, first_err;

    // Stall instance
    logic        start2;
    logic [15:0] len2;
    logic [31:0] m2_data;
    logic        m2_valid, m2_ready, s2_valid, s2_ready;
    logic        busy2, done2, pass2, tmo2;
    logic [15:0] err_cnt2, first_err2;

    // Register slice standing in for the path under test
    logic [31:0] rs_data;
    logic        rs_valid;
    logic        inject;

    // Monitor state
    int unsigned cyc = 0;
    int unsigned s_total = 0, mv_total = 0, last_s_edge = 0, done_edge = 0;
    int unsigned s2_total = 0, last_s2_edge = 0, done2_edge = 0;
    int unsigned s_base = 0, mv_base = 0, s2_base = 0;
    logic [31:0] mlog[$];
    int unsigned medge[$];
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    int n_checks = 0;
    int n_errors = 0;

    axis_loopback_bist #(
        .DATA_W (32),
        .LEN_W  (16),
        .TO_W   (10),
        .SEED   (16'hACE1)
    ) dut (
        .clk_i           (clk),
        .arstn_i         (rst_n),
        .start_i         (start),
        .len_i           (len),
        .throttle_en_i   (throttle),
        .bp_en_i         (bp),
        .m_axis_tdata_o  (m_data),
        .m_axis_tvalid_o (m_valid),
        .m_axis_tready_i (m_ready),
        .s_axis_tdata_i  (s_data),
        .s_axis_tvalid_i (s_valid),
        .s_axis_tready_o (s_ready),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .timeout_o       (tmo),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_err)
    );

    axis_loopback_bist #(
        .DATA_W (32),
        .LEN_W  (16),
        .TO_W   (4),
        .SEED   (16'hACE1)
    ) dut_to (
        .clk_i           (clk),
        .arstn_i         (rst_n),
        .start_i         (start2),
        .len_i           (len2),
        .throttle_en_i   (1'b0),
        .bp_en_i         (1'b0),
        .m_axis_tdata_o  (m2_data),
        .m_axis_tvalid_o (m2_valid),
        .m_axis_tready_i (m2_ready),
        .s_axis_tdata_i  (m2_data),
        .s_axis_tvalid_i (s2_valid),
        .s_axis_tready_o (s2_ready),
        .busy_o          (busy2),
        .done_o          (done2),
        .pass_o          (pass2),
        .timeout_o       (tmo2),
        .err_cnt_o       (err_cnt2),
        .first_err_idx_o (first_err2)
    );

    assign m_ready  = !rs_valid || s_ready;
    assign s_valid  = rs_valid;
    assign s_data   = (inject && (s_total - s_base == 5)) ? (rs_data ^ 32'd1) : rs_data;
    // Stall path: the first three words pass, then its output valid is forced low
    assign s2_valid = m2_valid && ((s2_total - s2_base) < 3);
    assign m2_ready = s2_ready && ((s2_total - s2_base) < 3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid <= 1'b0;
            rs_data  <= '0;
        end else if (m_ready) begin
            rs_valid <= m_valid;
            rs_data  <= m_data;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (m_valid && m_ready) begin
                mlog.push_back(m_data);
                medge.push_back(cyc);
            end
            if (m_valid) mv_total <= mv_total + 1;
            if (s_valid && s_ready) begin
                s_total     <= s_total + 1;
                last_s_edge <= cyc;
            end
            if (done) done_edge <= cyc;
            if (s2_valid && s2_ready) begin
                s2_total     <= s2_total + 1;
                last_s2_edge <= cyc;
            end
            if (done2) done2_edge <= cyc;
        end
    end

    // Master-side stability: a valid that was not accepted must persist unchanged
    always @(posedge clk) begin
        if (rst_n && prev_hold) check("hold_stable", {m_valid, m_data}, {1'b1, prev_data});
        prev_hold <= rst_n && m_valid && !m_ready;
        prev_data <= m_data;
    end

    task automatic start_main(input logic [15:0] l, input logic thr, input logic bpv);
        @(negedge clk);
        throttle = thr;
        bp       = bpv;
        len      = l;
        start    = 1'b1;
        mlog.delete();
        medge.delete();
        s_base   = s_total;
        mv_base  = mv_total;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input bit second, input int unsigned budget, output bit ok);
        ok = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((!second && done) || (second && done2)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", tmo, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_first_err", first_err, 16'hFFFF);
        check("rst_m_valid", m_valid, 0);
        check("rst_s_ready", s_ready, 0);
        check("rst_timeout2", tmo2, 0);
    endtask

    initial begin
        bit ok;
        int unsigned bad;

        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        throttle = 1'b0;
        bp       = 1'b0;
        inject   = 1'b0;
        start2   = 1'b0;
        len2     = '0;

        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean run, len=8
        start_main(16'd8, 1'b0, 1'b0);
        check("clean_busy_n1", busy, 1);
        check("clean_valid_n1", m_valid, 1);
        check("clean_data_n1", m_data, 0);
        wait_done(1'b0, 50, ok);
        check("clean_done_seen", ok, 1);
        check("clean_busy_in_done", busy, 0);
        @(negedge clk);
        check("clean_done_pulse", done, 0);
        check("clean_done_latency", done_edge - last_s_edge, 1);
        check("clean_words_tx", mlog.size(), 8);
        for (int i = 0; i < 8; i++) check("clean_data", mlog[i], i);
        check("clean_back_to_back", medge[medge.size()-1] - medge[0], 7);
        check("clean_words_rx", s_total - s_base, 8);
        check("clean_pass", pass, 1);
        check("clean_err_cnt", err_cnt, 0);
        check("clean_first_err", first_err, 16'hFFFF);
        check("clean_timeout", tmo, 0);

        // Error injection on returned word 5, len=10
        inject = 1'b1;
        start_main(16'd10, 1'b0, 1'b0);
        wait_done(1'b0, 60, ok);
        check("err_done_seen", ok, 1);
        @(negedge clk);
        inject = 1'b0;
        check("err_err_cnt", err_cnt, 1);
        check("err_first_idx", first_err, 5);
        check("err_pass", pass, 0);
        check("err_timeout", tmo, 0);

        // Zero length
        start_main(16'd0, 1'b0, 1'b0);
        check("zero_done_n1", done, 1);
        check("zero_busy_n1", busy, 0);
        check("zero_pass", pass, 1);
        check("zero_err_cnt", err_cnt, 0);
        check("zero_first_err", first_err, 16'hFFFF);
        @(negedge clk);
        check("zero_done_pulse", done, 0);
        check("zero_no_valid", mv_total - mv_base, 0);

        // Stress with gaps and backpressure, len=100
        start_main(16'd100, 1'b1, 1'b1);
        wait_done(1'b0, 3000, ok);
        check("stress_done_seen", ok, 1);
        @(negedge clk);
        check("stress_pass", pass, 1);
        check("stress_err_cnt", err_cnt, 0);
        check("stress_timeout", tmo, 0);
        check("stress_words_tx", mlog.size(), 100);
        check("stress_words_rx", s_total - s_base, 100);
        bad = 0;
        for (int i = 0; i < mlog.size(); i++) if (mlog[i] !== i) bad++;
        check("stress_data_bad", bad, 0);
        throttle = 1'b0;
        bp       = 1'b0;

        // Stall on the TO_W=4 instance
        @(negedge clk);
        s2_base = s2_total;
        len2    = 16'd10;
        start2  = 1'b1;
        @(negedge clk);
        start2  = 1'b0;
        wait_done(1'b1, 200, ok);
        check("stall_done_seen", ok, 1);
        @(negedge clk);
        check("stall_timeout", tmo2, 1);
        check("stall_pass", pass2, 0);
        check("stall_err_cnt", err_cnt2, 0);
        check("stall_words_rx", s2_total - s2_base, 3);
        check("stall_done_latency", done2_edge - last_s2_edge, 16);

        // Reset after 3 words, then a clean len=4 run
        start_main(16'd20, 1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (s_total - s_base >= 3) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rr_three_words", ok, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_idle_busy", busy, 0);
        start_main(16'd4, 1'b0, 1'b0);
        wait_done(1'b0, 50, ok);
        check("rr_done_seen", ok, 1);
        @(negedge clk);
        check("rr_words_tx", mlog.size(), 4);
        for (int i = 0; i < 4; i++) check("rr_data", mlog[i], i);
        check("rr_words_rx", s_total - s_base, 4);
        check("rr_pass", pass, 1);
        check("rr_err_cnt", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_loopback_bist.md
# axis_loopback_bist

Self-checking AXI-Stream traffic endpoint for both ends of a stream path. Its master side sources a deterministic incrementing-word sequence into the path under test, for example an AXI-Stream register slice. Its slave side sinks the path output and compares each word against the expected sequence. Optional LFSR-driven valid gaps and ready backpressure exercise the handshake, and a watchdog catches stalled paths.

## Interface
- DATA_W, 32: tdata width on both stream ports.
- LEN_W, 16: width of the sequence length and of the counters.
- TO_W, 10: watchdog width; the timeout is 2^TO_W cycles without a received word.
- SEED, 16'hACE1: LFSR seed; must be nonzero.
- clk_i  in  1  single clock; all logic is on the rising edge.
- arstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  run request, sampled only in IDLE.
- len_i  in  LEN_W  number of words to send and receive; sampled with start_i.
- throttle_en_i  in  1  enables random tvalid gaps on the master side.
- bp_en_i  in  1  enables random tready deassertion on the slave side.
- m_axis_tdata_o  out  DATA_W  generated word.
- m_axis_tvalid_o  out  1  master valid.
- m_axis_tready_i  in  1  ready from the path under test.
- s_axis_tdata_i  in  DATA_W  word returned by the path under test.
- s_axis_tvalid_i  in  1  slave valid.
- s_axis_tready_o  out  1  slave ready.
- busy_o  out  1  high while in RUN.
- done_o  out  1  one-cycle completion pulse.
- pass_o  out  1  result of the last run; held until the next start.
- timeout_o  out  1  the last run was aborted by the watchdog.
- err_cnt_o  out  LEN_W  mismatch count; saturates at all-ones.
- first_err_idx_o  out  LEN_W  index of the first mismatch; all-ones if there is none.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE to RUN: on start_i=1. The block latches len_i, clears tx_cnt, rx_cnt, err_cnt and the watchdog, and sets first_err_idx to all-ones.
- IDLE to DONE: on start_i=1 with len_i=0. No word is sent.
- RUN to DONE:
  - when rx_cnt reaches len after a slave handshake, or
  - when the watchdog expires, which also sets timeout_o=1.
- DONE to IDLE: unconditionally after one cycle. done_o=1 only in DONE.
- start_i is ignored outside IDLE.
- Generator:
  - tdata = tx_cnt zero-extended or truncated to DATA_W, so it wraps modulo 2^DATA_W.
  - tvalid may rise in RUN only while tx_cnt < len.
  - Gap rule: with throttle_en_i=1, tvalid is withheld in any cycle where lfsr[0]=1 and tvalid is currently low.
  - Once tvalid is high, tvalid and tdata are held until m_axis_tready_i=1. A gap never withdraws a valid.
  - tx_cnt increments on each handshake.
- Checker:
  - s_axis_tready_o=1 in RUN, except when bp_en_i=1 and lfsr[1]=1.
  - s_axis_tready_o=0 in IDLE and DONE.
  - On each handshake the block compares s_axis_tdata_i with rx_cnt modulo 2^DATA_W.
  - On a mismatch, err_cnt increments with saturation. first_err_idx takes rx_cnt if it is still all-ones.
  - rx_cnt increments on each handshake.
- LFSR: 16-bit Fibonacci, taps 16/14/13/11. It loads SEED at reset and advances every cycle in RUN.
- Watchdog: cleared on each slave handshake and on start; it counts in RUN. It expires when the count reaches 2^TO_W-1.
- pass_o is set on entry to DONE: pass_o = (err_cnt==0) and not timeout.
- pass_o, timeout_o, err_cnt_o and first_err_idx_o hold their values until the next accepted start.

## Timing
- Reset value of every output is 0, except first_err_idx_o, which resets to all-ones.
- Reset mid-run: the next cycle is IDLE with all outputs at their reset values. Any in-flight word is dropped.
- Start latency: start_i is sampled at edge N. busy_o and the first possible m_axis_tvalid_o are high after edge N, in cycle N+1.
- Completion: done_o is high in the cycle after the edge that accepts the len-th slave handshake. busy_o is low in that same cycle.
- Throughput: one word per cycle per side when gaps and backpressure are disabled.
- Simultaneous handshakes on the master and slave sides in the same cycle are both counted.

## Structure
- axis_bist_pkg holds:
  - the state enum (IDLE/RUN/DONE),
  - the LFSR tap mask,
  - the default SEED,
  - a function next_lfsr().
- One sub-module, axis_bist_lfsr, contains the 16-bit LFSR with seed and enable.
- The generator and checker share this one LFSR instance through separate bits.

## Test plan
- Clean run: len=8 through an axis_reg with both enables 0. Required: tdata 0..7 back-to-back, done_o in the cycle after the 8th slave handshake, pass_o=1, err_cnt_o=0.
- Stress run: len=100 with throttle and backpressure enabled. Required: an assertion confirms tvalid and tdata stay stable while valid=1 and ready=0, and the run ends with pass_o=1.
- Error injection: the bench flips tdata bit 0 on returned word 5 with len=10. Required: err_cnt_o=1, first_err_idx_o=5, pass_o=0.
- Zero length: len=0. Required: done_o in cycle N+1, pass_o=1, tvalid never asserted.
- Stall: TO_W=4 and the path's output valid forced to 0. Required: timeout_o=1 and done_o pulse 16 cycles after the last handshake, pass_o=0.
- Reset recovery: arstn_i asserted after 3 words, then a new start with len=4. Required: outputs at reset values, then a clean 0..3 run with pass_o=1.
